// File: rtl/delay_line_pkg.sv
// delay_line_pkg: shared clocking constants and burst receiver state type
package delay_line_pkg;
  localparam int CLK_FREQ = 135_000_000;
  localparam int MODULATION_FREQ = 13_500_000;
  localparam int CLKS_PER_HALF_PERIOD = CLK_FREQ / MODULATION_FREQ / 2;
  // 1.5 us of continuous low, rounded down to whole clocks
  localparam int HOLDOFF_CYCLES = (CLK_FREQ / 1000) * 3 / 2000;
  localparam int TS_WIDTH = 18;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, HOLDOFF} burst_rx_state_t;
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: two-flop synchroniser for asynchronous input pins
// Ports: clk, rst (async, active high) | d raw input | q synchronised output
module sync_ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta <= '0;
      q <= '0;
    end else begin
      meta <= d;
      q <= meta;
    end
endmodule

// File: rtl/burst_rx.sv
// burst_rx: demodulates a carrier burst, validates timing and count, timestamps its start
// Ports: clk, rst (async, active high) | in raw burst pin | ts_in free-running delay counter
//        burst_valid / burst_err one-cycle result strobes | burst_ts / burst_pulses held results
//        busy high whenever the receiver is not armed in IDLE
module burst_rx #(
  parameter int CLKS_PER_HALF_PERIOD = delay_line_pkg::CLKS_PER_HALF_PERIOD,
  parameter int HALF_PERIOD_TOL = 1,
  parameter int MIN_PULSES = 3,
  parameter int MAX_PULSES = 12,
  parameter int HOLDOFF_CYCLES = delay_line_pkg::HOLDOFF_CYCLES,
  parameter int TS_WIDTH = delay_line_pkg::TS_WIDTH,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  input  logic [TS_WIDTH-1:0]  ts_in,
  output logic                 burst_valid,
  output logic                 burst_err,
  output logic [TS_WIDTH-1:0]  burst_ts,
  output logic [CNT_WIDTH-1:0] burst_pulses,
  output logic                 busy
);
  import delay_line_pkg::*;
  localparam int LO = CLKS_PER_HALF_PERIOD - HALF_PERIOD_TOL;
  localparam int HI = CLKS_PER_HALF_PERIOD + HALF_PERIOD_TOL;
  localparam int RUN_MAX = imax(HOLDOFF_CYCLES, HI + 1);
  localparam int RW = $clog2(RUN_MAX + 1);
  localparam int CW = CNT_WIDTH + 1;
  burst_rx_state_t state, state_nxt;
  logic in_s, in_d, rise, fall, in_window, timeout, quiet, too_many, enough;
  logic valid_nxt, err_nxt, load, step;
  logic [RW-1:0] run_ctr;
  logic [CNT_WIDTH-1:0] pulse_cnt;
  logic [CW-1:0] cnt_inc;

  sync_ff u_sync (.clk(clk), .rst(rst), .d(in), .q(in_s));

  always_ff @(posedge clk or posedge rst)
    if (rst) in_d <= 1'b0;
    else in_d <= in_s;

  assign rise = in_s & ~in_d;
  assign fall = ~in_s & in_d;

  // Reads as the length of the level that just ended when sampled on an edge cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) run_ctr <= '0;
    else if (rise || fall) run_ctr <= RW'(1);
    else if (run_ctr != RW'(RUN_MAX)) run_ctr <= run_ctr + 1'b1;

  assign in_window = run_ctr >= RW'(LO) && run_ctr <= RW'(HI);
  // No edge yet with run_ctr at HI means the current level is already longer than HI
  assign timeout = run_ctr >= RW'(HI);
  assign quiet = ~in_s && ~in_d && run_ctr >= RW'(HOLDOFF_CYCLES - 1);
  // One extra bit so an over-long burst is caught before the count can wrap
  assign cnt_inc = CW'(pulse_cnt) + CW'(1);
  assign too_many = cnt_inc > CW'(MAX_PULSES);
  assign enough = pulse_cnt >= CNT_WIDTH'(MIN_PULSES);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = rise ? HIGH : IDLE;
      HIGH:    state_nxt = fall ? (in_window ? LOW : HOLDOFF) : (timeout ? HOLDOFF : HIGH);
      LOW:     state_nxt = rise ? (in_window && !too_many ? HIGH : HOLDOFF) : (timeout ? HOLDOFF : LOW);
      default: state_nxt = quiet ? IDLE : HOLDOFF;
    endcase
  end

  always_comb begin
    load = state == IDLE && rise;
    step = state == LOW && rise && in_window;
    err_nxt = state == HIGH ? (fall ? !in_window : timeout)
            : state == LOW ? (rise ? (!in_window || too_many) : (timeout && !enough))
            : 1'b0;
    valid_nxt = state == LOW && !rise && timeout && enough;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      burst_valid <= 1'b0;
      burst_err <= 1'b0;
      burst_ts <= '0;
      burst_pulses <= '0;
      pulse_cnt <= '0;
    end else begin
      burst_valid <= valid_nxt;
      burst_err <= err_nxt;
      if (load) burst_ts <= ts_in;
      if (load) pulse_cnt <= CNT_WIDTH'(1);
      else if (step) pulse_cnt <= cnt_inc[CNT_WIDTH-1:0];
      if (valid_nxt || err_nxt) burst_pulses <= step ? cnt_inc[CNT_WIDTH-1:0] : pulse_cnt;
    end

  assign busy = state != IDLE;
endmodule

// File: tb/tb_burst_rx.sv
// tb_burst_rx: scoreboard bench for burst_rx
module tb_burst_rx;
  import delay_line_pkg::*;
  localparam int LAT = 9;
  localparam int RISE_LAT = 3;
  typedef struct {
    logic val;
    logic err;
    logic [3:0] pulses;
    logic [TS_WIDTH-1:0] ts;
    int cyc;
  } rec_t;
  logic clk = 1'b0, rst = 1'b1, in = 1'b0;
  logic [TS_WIDTH-1:0] ts_in, burst_ts;
  logic [TS_WIDTH-1:0] ts_off = '0, exp_ts = '0;
  logic burst_valid, burst_err, busy;
  logic [3:0] burst_pulses;
  int cyc = 0, total = 0, bad = 0, last_rise = 0, last_fall = 0;
  rec_t exp_q[$], obs_q[$];

  burst_rx dut (
    .clk(clk), .rst(rst), .in(in), .ts_in(ts_in),
    .burst_valid(burst_valid), .burst_err(burst_err),
    .burst_ts(burst_ts), .burst_pulses(burst_pulses), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ts_in = ts_off + TS_WIDTH'(cyc);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (burst_valid || burst_err)
        obs_q.push_back(rec_t'{burst_valid, burst_err, burst_pulses, burst_ts, cyc});
    end
  endtask

  // ts0 is the counter value expected at the synchronised first rise (two clocks after the pin)
  task automatic burst(input int n, input int hi, input int lo, input logic [TS_WIDTH-1:0] ts0,
                       input int last_hi = 0, input bit alt = 1'b0);
    ts_off = ts0 - TS_WIDTH'(2) - TS_WIDTH'(cyc);
    exp_ts = ts0;
    for (int i = 0; i < n; i++) begin
      in = 1'b1;
      last_rise = cyc;
      tick(i == n - 1 && last_hi > 0 ? last_hi : (alt && i % 2 == 1 ? lo : hi));
      in = 1'b0;
      last_fall = cyc;
      tick(alt && i % 2 == 1 ? hi : lo);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) tick();
    tick(3);
  endtask

  task automatic settle();
    for (int i = 0; i < 400 && busy === 1'b1; i++) tick();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total += 5;
    if (burst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", burst_valid); end
    if (burst_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", burst_err); end
    if (burst_ts !== '0) begin bad++; $display("FAIL reset_ts got=%0d want=0", burst_ts); end
    if (burst_pulses !== 4'd0) begin bad++; $display("FAIL reset_pulses got=%0d want=0", burst_pulses); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_nominal();
    string tn = "nominal";
    rec_t e, o;
    burst(12, 5, 5, TS_WIDTH'(1000));
    exp_q.push_back(rec_t'{1'b1, 1'b0, 4'd12, exp_ts, last_fall + LAT});
    drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tn, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 4;
      if ({o.val, o.err} !== {e.val, e.err}) begin bad++; $display("FAIL %s_kind got v=%b e=%b want v=%b e=%b", tn, o.val, o.err, e.val, e.err); end
      if (o.pulses !== e.pulses) begin bad++; $display("FAIL %s_pulses got=%0d want=%0d", tn, o.pulses, e.pulses); end
      if (o.ts !== e.ts) begin bad++; $display("FAIL %s_ts got=%0d want=%0d", tn, o.ts, e.ts); end
      if (o.cyc !== e.cyc) begin bad++; $display("FAIL %s_cycle got=%0d want=%0d", tn, o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
    settle();
  endtask

  task automatic test_jitter();
    string tn = "jitter";
    rec_t e, o;
    burst(8, 4, 6, TS_WIDTH'(5000), 0, 1'b1);
    exp_q.push_back(rec_t'{1'b1, 1'b0, 4'd8, exp_ts, last_fall + LAT});
    settle();
    burst(4, 5, 5, TS_WIDTH'(6000), 7);
    exp_q.push_back(rec_t'{1'b0, 1'b1, 4'd4, exp_ts, last_rise + LAT});
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s_holdoff_busy got=%b want=1", tn, busy); end
    drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tn, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 4;
      if ({o.val, o.err} !== {e.val, e.err}) begin bad++; $display("FAIL %s_kind got v=%b e=%b want v=%b e=%b", tn, o.val, o.err, e.val, e.err); end
      if (o.pulses !== e.pulses) begin bad++; $display("FAIL %s_pulses got=%0d want=%0d", tn, o.pulses, e.pulses); end
      if (o.ts !== e.ts) begin bad++; $display("FAIL %s_ts got=%0d want=%0d", tn, o.ts, e.ts); end
      if (o.cyc !== e.cyc) begin bad++; $display("FAIL %s_cycle got=%0d want=%0d", tn, o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
    settle();
  endtask

  task automatic test_count_limits();
    string tn = "count";
    rec_t e, o;
    burst(2, 5, 5, TS_WIDTH'(7000));
    exp_q.push_back(rec_t'{1'b0, 1'b1, 4'd2, exp_ts, last_fall + LAT});
    settle();
    burst(13, 5, 5, TS_WIDTH'(8000));
    exp_q.push_back(rec_t'{1'b0, 1'b1, 4'd13, exp_ts, last_rise + RISE_LAT});
    drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tn, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 4;
      if ({o.val, o.err} !== {e.val, e.err}) begin bad++; $display("FAIL %s_kind got v=%b e=%b want v=%b e=%b", tn, o.val, o.err, e.val, e.err); end
      if (o.pulses !== e.pulses) begin bad++; $display("FAIL %s_pulses got=%0d want=%0d", tn, o.pulses, e.pulses); end
      if (o.ts !== e.ts) begin bad++; $display("FAIL %s_ts got=%0d want=%0d", tn, o.ts, e.ts); end
      if (o.cyc !== e.cyc) begin bad++; $display("FAIL %s_cycle got=%0d want=%0d", tn, o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
    settle();
  endtask

  task automatic test_holdoff();
    string tn = "holdoff";
    rec_t e, o;
    burst(3, 5, 5, TS_WIDTH'(9000));
    exp_q.push_back(rec_t'{1'b1, 1'b0, 4'd3, exp_ts, last_fall + LAT});
    tick(95);
    burst(12, 5, 5, TS_WIDTH'(9500));
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy got=%b want=1", tn, busy); end
    tick(245);
    burst(3, 5, 5, TS_WIDTH'(12345));
    exp_q.push_back(rec_t'{1'b1, 1'b0, 4'd3, exp_ts, last_fall + LAT});
    drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tn, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 4;
      if ({o.val, o.err} !== {e.val, e.err}) begin bad++; $display("FAIL %s_kind got v=%b e=%b want v=%b e=%b", tn, o.val, o.err, e.val, e.err); end
      if (o.pulses !== e.pulses) begin bad++; $display("FAIL %s_pulses got=%0d want=%0d", tn, o.pulses, e.pulses); end
      if (o.ts !== e.ts) begin bad++; $display("FAIL %s_ts got=%0d want=%0d", tn, o.ts, e.ts); end
      if (o.cyc !== e.cyc) begin bad++; $display("FAIL %s_cycle got=%0d want=%0d", tn, o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
    settle();
  endtask

  task automatic test_reset_mid_burst();
    string tn = "midreset";
    rec_t e, o;
    burst(5, 5, 5, TS_WIDTH'(7777));
    in = 1'b1;
    tick(2);
    rst = 1'b1;
    #1;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b want=0", tn, busy); end
    if (burst_valid !== 1'b0) begin bad++; $display("FAIL %s_valid got=%b want=0", tn, burst_valid); end
    if (burst_err !== 1'b0) begin bad++; $display("FAIL %s_err got=%b want=0", tn, burst_err); end
    if (burst_ts !== '0) begin bad++; $display("FAIL %s_ts_cleared got=%0d want=0", tn, burst_ts); end
    if (burst_pulses !== 4'd0) begin bad++; $display("FAIL %s_pulses_cleared got=%0d want=0", tn, burst_pulses); end
    in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(5);
    burst(3, 5, 5, TS_WIDTH'(4242));
    exp_q.push_back(rec_t'{1'b1, 1'b0, 4'd3, exp_ts, last_fall + LAT});
    drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tn, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 4;
      if ({o.val, o.err} !== {e.val, e.err}) begin bad++; $display("FAIL %s_kind got v=%b e=%b want v=%b e=%b", tn, o.val, o.err, e.val, e.err); end
      if (o.pulses !== e.pulses) begin bad++; $display("FAIL %s_pulses got=%0d want=%0d", tn, o.pulses, e.pulses); end
      if (o.ts !== e.ts) begin bad++; $display("FAIL %s_ts got=%0d want=%0d", tn, o.ts, e.ts); end
      if (o.cyc !== e.cyc) begin bad++; $display("FAIL %s_cycle got=%0d want=%0d", tn, o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
    settle();
  endtask

  task automatic test_ts_wrap();
    string tn = "tswrap";
    rec_t e, o;
    burst(4, 5, 5, TS_WIDTH'(262143));
    exp_q.push_back(rec_t'{1'b1, 1'b0, 4'd4, TS_WIDTH'(262143), last_fall + LAT});
    drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tn, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 4;
      if ({o.val, o.err} !== {e.val, e.err}) begin bad++; $display("FAIL %s_kind got v=%b e=%b want v=%b e=%b", tn, o.val, o.err, e.val, e.err); end
      if (o.pulses !== e.pulses) begin bad++; $display("FAIL %s_pulses got=%0d want=%0d", tn, o.pulses, e.pulses); end
      if (o.ts !== e.ts) begin bad++; $display("FAIL %s_ts got=%0d want=%0d", tn, o.ts, e.ts); end
      if (o.cyc !== e.cyc) begin bad++; $display("FAIL %s_cycle got=%0d want=%0d", tn, o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
    settle();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_jitter();
    test_count_limits();
    test_holdoff();
    test_reset_mid_burst();
    test_ts_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
